// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction store,
// little-endian, one byte per cycle, while holding the CPU stalled.
module inst_mem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_adr,
  input  logic [15:0]       word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [7:0]        mem_din,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              wrap_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       data_q, data_d;
  logic              wrap_err_q, wrap_err_d;

  // One extra bit so the carry out of the top of the store is visible.
  logic [ADDR_W:0]   ptr_inc;
  assign ptr_inc = {1'b0, ptr_q} + (ADDR_W+1)'(4);

  // Alignment bits and bits above the store size are intentionally dropped.
  logic unused_base_bits;
  assign unused_base_bits = ^{base_adr[31:ADDR_W], base_adr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      byte_idx_q  <= '0;
      data_q      <= '0;
      wrap_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      data_q      <= data_d;
      wrap_err_q  <= wrap_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    data_d      = data_q;
    wrap_err_d  = wrap_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d       = {base_adr[ADDR_W-1:2], 2'b00};
          remaining_d = word_count;
          byte_idx_d  = 2'd0;
          wrap_err_d  = 1'b0;
          state_d     = (word_count == 16'd0) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        // in_ready is high throughout ACCEPT, so in_valid alone completes a transfer.
        if (in_valid) begin
          data_d     = in_data;
          byte_idx_d = 2'd0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          ptr_d       = ptr_inc[ADDR_W-1:0];
          remaining_d = remaining_q - 16'd1;
          // Only flag a wrap when another word will actually land at address 0.
          if (ptr_inc[ADDR_W] && (remaining_q > 16'd1))
            wrap_err_d = 1'b1;
          state_d = (remaining_q == 16'd1) ? DONE : ACCEPT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == ACCEPT);
  assign mem_we   = (state_q == WRITE);
  assign mem_adr  = mem_we ? (ptr_q + ADDR_W'(byte_idx_q)) : '0;
  assign mem_din  = mem_we ? data_q[8*byte_idx_q +: 8] : 8'd0;
  assign busy     = (state_q != IDLE);
  assign cpu_hold = busy;
  assign done     = (state_q == DONE);
  assign wrap_err = wrap_err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized bench for inst_mem_loader: a byte-level write model predicts every
// store write, the final memory image, done pulses and the sticky wrap flag.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_adr;
  logic [7:0]  mem_din;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        wrap_err;

  inst_mem_loader #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_adr   (base_adr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_adr    (mem_adr),
    .mem_din    (mem_din),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .wrap_err   (wrap_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] adr;
    logic [7:0]  din;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] img     [65536];
  logic [7:0] ref_mem [65536];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Store-side monitor: every write must be the next one the model predicted.
  always @(negedge clk) begin
    if (mem_we) begin
      img[mem_adr] <= mem_din;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", {16'd0, mem_adr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("wr_adr", {16'd0, mem_adr}, {16'd0, mon_e.adr});
        check_eq("wr_din", {24'd0, mem_din}, {24'd0, mon_e.din});
      end
    end else begin
      check_eq("idle_adr", {16'd0, mem_adr}, 32'd0);
      check_eq("idle_din", {24'd0, mem_din}, 32'd0);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic predict_word(input logic [15:0] p, input int w, input logic [31:0] wd, input int nbytes);
    wr_t e;
    for (int b = 0; b < nbytes; b++) begin
      e.adr = p + 16'(4 * w + b);
      e.din = wd[8*b +: 8];
      exp_q.push_back(e);
      ref_mem[e.adr] = e.din;
    end
  endtask

  task automatic run_session(input logic [31:0] base, input int count, input int stall,
                             input bit poke_start, input bit fix0, input logic [31:0] w0);
    logic [31:0] words[$];
    logic [31:0] wd;
    logic [15:0] p;
    logic        exp_wrap;
    int          t;
    int          d0;
    p = base[15:0] & 16'hFFFC;
    for (int w = 0; w < count; w++) begin
      wd = (fix0 && w == 0) ? w0 : $urandom;
      words.push_back(wd);
      predict_word(p, w, wd, 4);
    end
    // A wrap is flagged only if some non-final word ends exactly at the top.
    exp_wrap = (count > 0) && ((32'(p) + 32'(4 * (count - 1))) >= 32'h1_0000);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_adr = base; word_count = 16'(count);
    @(posedge clk); #1;
    start = 1'b0; base_adr = $urandom; word_count = 16'($urandom);
    check_eq("wrap_clr_on_start", {31'd0, wrap_err}, 32'd0);
    if (count == 0) begin
      @(negedge clk);
      check_eq("cnt0_done", {31'd0, done}, 32'd1);
      check_eq("cnt0_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("cnt0_we", {31'd0, mem_we}, 32'd0);
      check_eq("cnt0_busy", {31'd0, busy}, 32'd1);
    end
    for (int w = 0; w < count; w++) begin
      in_valid = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        check_eq("stall_we", {31'd0, mem_we}, 32'd0);
        check_eq("stall_hold", {31'd0, cpu_hold}, 32'd1);
      end
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      check_eq("accept_ready", {31'd0, in_ready}, 32'd1);
      if (!in_ready) begin
        exp_q.delete();
        return;
      end
      in_valid = 1'b1;
      in_data  = words[w];
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        check_eq("write_we", {31'd0, mem_we}, 32'd1);
        if (poke_start && w == 0 && k == 2) begin
          start = 1'b1; word_count = 16'd7;
        end
        if (k == 3) start = 1'b0;
      end
      @(negedge clk);
      if (w == count - 1) begin
        check_eq("last_done", {31'd0, done}, 32'd1);
        check_eq("last_in_ready", {31'd0, in_ready}, 32'd0);
      end else begin
        check_eq("next_in_ready", {31'd0, in_ready}, 32'd1);
      end
    end
    @(negedge clk);
    check_eq("end_done_low", {31'd0, done}, 32'd0);
    check_eq("end_busy", {31'd0, busy}, 32'd0);
    check_eq("end_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_eq("end_wrap_err", {31'd0, wrap_err}, {31'd0, exp_wrap});
    check_eq("done_pulses", 32'(done_cnt - d0), 32'd1);
    check_eq("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          d0;
    int          bad;
    logic [31:0] wd;
    logic [31:0] base;
    for (int i = 0; i < 65536; i++) begin
      img[i]     = 8'd0;
      ref_mem[i] = 8'd0;
    end
    rst = 1'b1; start = 1'b0; base_adr = '0; word_count = '0; in_valid = 1'b0; in_data = '0;
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_mem_adr", {16'd0, mem_adr}, 32'd0);
    check_eq("rst_mem_din", {24'd0, mem_din}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_wrap_err", {31'd0, wrap_err}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_session(32'h0000_0000, 1, 0, 1'b0, 1'b1, 32'h8C01_03E8);
    check_eq("imem_word0", {img[3], img[2], img[1], img[0]}, 32'h8C01_03E8);
    run_session(32'h0000_0010, 3, 10, 1'b0, 1'b0, 32'd0);
    run_session(32'h0000_1234, 0, 0, 1'b0, 1'b0, 32'd0);
    run_session(32'h0000_0013, 1, 0, 1'b0, 1'b0, 32'd0);
    run_session(32'h0000_FFFC, 2, 1, 1'b0, 1'b0, 32'd0);
    run_session(32'h0000_0100, 2, 0, 1'b1, 1'b0, 32'd0);

    // Reset in the middle of a word: bytes 0..2 land, byte 3 and done never appear.
    wd = $urandom;
    predict_word(16'h0040, 0, wd, 3);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_adr = 32'h40; word_count = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = wd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_we", {31'd0, mem_we}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("midrst_pending", 32'(exp_q.size()), 32'd0);
    run_session(32'h0000_0040, 1, 0, 1'b0, 1'b0, 32'd0);

    for (int s = 0; s < 12; s++) begin
      base = ($urandom_range(0, 1) == 1) ? (32'h0000_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      run_session(base, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'b0, 32'd0);
    end

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 65536; i++)
      if (img[i] !== ref_mem[i]) bad++;
    check_eq("mem_image_mismatches", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Write-side companion of the instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes them into the 64 KiB byte-wide instruction store, little-endian, one byte per cycle. It sits between a boot/debug source (testbench, UART bridge) and the instruction memory's byte write port. It holds the CPU stalled while a program image is being loaded.

## Interface
Parameters:
- ADDR_W, 16, byte address width of the instruction store (64 KiB).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a load session; sampled only in IDLE.
- base_adr  input  32  start byte address; bits [1:0] forced to 0, bits above ADDR_W-1 ignored.
- word_count  input  16  number of words to load; 0 is legal.
- in_valid  input  1  source has a word on in_data.
- in_data  input  32  instruction word; byte 0 = in_data[7:0].
- in_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  byte write strobe to instruction store.
- mem_adr  output  ADDR_W  byte write address.
- mem_din  output  8  byte write data.
- busy  output  1  session in progress.
- cpu_hold  output  1  stall request to the CPU; equals busy.
- done  output  1  one-cycle pulse at session end.
- wrap_err  output  1  sticky: address wrapped past top of store during the session.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE. All outputs Moore-decoded from registers; no input-to-output combinational path.
- IDLE: in_ready=0, busy=0. On start=1: latch ptr = {base_adr[ADDR_W-1:2],2'b00}, remaining = word_count, clear wrap_err. If word_count==0 → DONE, else → ACCEPT.
- ACCEPT: in_ready=1. On in_valid&in_ready at the edge: latch in_data, byte_idx=0 → WRITE. in_valid low: stay, no writes.
- WRITE: mem_we=1, mem_adr = ptr + byte_idx, mem_din = data[8*byte_idx+7 : 8*byte_idx]; byte_idx 0..3, one per cycle. After byte 3: ptr += 4 (mod 2^ADDR_W), remaining -= 1; remaining reaching 0 → DONE, else → ACCEPT.
- Wrap: if ptr+4 overflows to 0 while remaining>1, set wrap_err; writing continues at address 0.
- DONE: done=1, busy=1 for one cycle → IDLE.
- busy = cpu_hold = (state != IDLE).
- start outside IDLE ignored. in_valid outside ACCEPT ignored (no transfer).
- mem_adr, mem_din driven 0 whenever mem_we=0.

## Timing
- Reset values: state IDLE; in_ready, mem_we, mem_adr, mem_din, busy, cpu_hold, done, wrap_err all 0; ptr, remaining, byte_idx, data 0.
- Reset mid-session: outputs clear immediately (async), state IDLE; bytes already written stay in memory; no done pulse.
- start sampled at edge E → ACCEPT (in_ready=1) from cycle E+1.
- Transfer at edge T → bytes 0..3 written in cycles T+1..T+4 → next ACCEPT at T+5, or DONE at T+5.
- Max throughput: 5 cycles/word. Minimum start→first mem_we: 2 cycles.
- word_count=0: done high in cycle E+1, IDLE at E+2.
- wrap_err valid from the cycle after the wrapping increment until next accepted start or reset.

## Test plan
- Reset, start base 0x0000 count 1, word 0x8C0103E8 → writes (0,E8),(1,03),(2,01),(3,8C) on consecutive cycles; done one cycle after last write; instruction memory reads 0x8C0103E8 at adr 0.
- base 0x0010 count 3, in_valid dropped 10 cycles between words → no mem_we during stall, busy/cpu_hold held high, addresses 0x10..0x1B contiguous, single done pulse.
- count 0 → done pulse the cycle after start, no mem_we, no in_ready; base 0x0013 count 1 → first write at 0x0010.
- base 0xFFFC count 2 → writes 0xFFFC..0xFFFF then 0x0000..0x0003, wrap_err=1 after session; next start clears it.
- start pulsed while in WRITE → ignored, session completes with original count.
- rst asserted during WRITE byte 2 → mem_we, busy, cpu_hold drop immediately, no done; subsequent start loads correctly.
